// File: rtl/aexm_pkg.sv
// -----------------------------------------------------------------------------
// aexm_pkg
//   Definitions shared by the aexm data-bus blocks:
//   - dbus_state_t : responder FSM states (2-bit encoding)
//   - dbus_size_t  : access size decoded from a byte-select
//   - SEL_*        : byte-select codes driven by the execute stage
//   - ERR_DATA     : load data returned on a bus error
//   - sel_size()   : byte-select to access-size decode
// -----------------------------------------------------------------------------
package aexm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RWAIT = 2'd2,
    ST_DONE  = 2'd3
  } dbus_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } dbus_size_t;

  // Byte lanes: bit 3 selects bits 31:24, bit 0 selects bits 7:0.
  localparam logic [3:0] SEL_B0  = 4'h1;
  localparam logic [3:0] SEL_B1  = 4'h2;
  localparam logic [3:0] SEL_B2  = 4'h4;
  localparam logic [3:0] SEL_B3  = 4'h8;
  localparam logic [3:0] SEL_HLO = 4'h3;
  localparam logic [3:0] SEL_HHI = 4'hC;
  localparam logic [3:0] SEL_W   = 4'hF;
  localparam logic [3:0] SEL_FSL = 4'h0;

  localparam logic [31:0] ERR_DATA = 32'h0;

  // Anything that is not a single byte or an aligned halfword is a word.
  function automatic dbus_size_t sel_size(input logic [3:0] sel);
    case (sel)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3: sel_size = SZ_BYTE;
      SEL_HLO, SEL_HHI:               sel_size = SZ_HALF;
      default:                        sel_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/aexm_dbus_lane.sv
// -----------------------------------------------------------------------------
// aexm_dbus_lane
//   Combinational byte-lane steering between the core's right-justified data
//   and a 32-bit memory word.
//   Write: the low byte/halfword is replicated across the word so whichever
//          lanes the byte enables select carry the right data.
//   Read : the lanes named by the select are shifted down and zero-extended.
//
//   i_wr_sel  [3:0]  byte-select for the write path
//   i_wr_data [31:0] right-justified store data
//   o_wr_data [31:0] lane-replicated write word
//   i_rd_sel  [3:0]  byte-select for the read path
//   i_rd_data [31:0] raw memory read word
//   o_rd_data [31:0] right-justified, zero-extended load data
// -----------------------------------------------------------------------------
module aexm_dbus_lane
  import aexm_pkg::*;
(
  input  logic [3:0]  i_wr_sel,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_wr_data,
  input  logic [3:0]  i_rd_sel,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_rd_data
);

  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    o_wr_data = i_wr_data;
    case (sel_size(i_wr_sel))
      SZ_BYTE: o_wr_data = {4{i_wr_data[7:0]}};
      SZ_HALF: o_wr_data = {2{i_wr_data[15:0]}};
      default: o_wr_data = i_wr_data;
    endcase
  end

  always_comb begin
    o_rd_data = i_rd_data;
    case (i_rd_sel)
      SEL_B3:  o_rd_data = {24'h0, i_rd_data[31:24]};
      SEL_B2:  o_rd_data = {24'h0, i_rd_data[23:16]};
      SEL_B1:  o_rd_data = {24'h0, i_rd_data[15:8]};
      SEL_B0:  o_rd_data = {24'h0, i_rd_data[7:0]};
      SEL_HHI: o_rd_data = {16'h0, i_rd_data[31:16]};
      SEL_HLO: o_rd_data = {16'h0, i_rd_data[15:0]};
      default: o_rd_data = i_rd_data;
    endcase
  end

endmodule

// File: rtl/aexm_dbus_resp.sv
// -----------------------------------------------------------------------------
// aexm_dbus_resp
//   Memory-side responder for the aexm load/store path. Takes one core access
//   at a time, runs it on a request/grant/rvalid memory port and returns a
//   one-cycle ack with right-justified load data. A bounded wait on grant or
//   read data turns into an ack with err=1.
//
//   Parameters
//     AW   memory word-address width (low AW bits of dwb_adr)
//     TMO  wait limit in cycles for mem_gnt / mem_rvalid, 1..255
//
//   Core side : gclk, grst (sync, active-high), dwb_stb, dwb_we, dwb_adr,
//               dwb_sel, dwb_do -> dwb_di, dwb_ack, dwb_err, dwb_busy
//   Memory    : mem_req, mem_we, mem_be, mem_addr, mem_wdata,
//               mem_gnt, mem_rvalid, mem_rdata
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module aexm_dbus_resp
  import aexm_pkg::*;
#(
  parameter int AW  = 27,
  parameter int TMO = 255
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          dwb_stb,
  input  logic          dwb_we,
  input  logic [31:0]   dwb_adr,
  input  logic [3:0]    dwb_sel,
  input  logic [31:0]   dwb_do,
  output logic [31:0]   dwb_di,
  output logic          dwb_ack,
  output logic          dwb_err,
  output logic          dwb_busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = 8;

  dbus_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_di;
  logic          r_ack;
  logic          r_err;
  logic          r_busy;
  logic          r_req;
  logic          r_we;
  logic [3:0]    r_be;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;

  dbus_state_t   w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [31:0]   w_di_nxt;
  logic          w_err_nxt;
  logic          w_accept;
  logic          w_tmo;
  logic [31:0]   w_wr_data;
  logic [31:0]   w_rd_data;

  // Write steering works on the live request so the steered word is captured
  // at acceptance; extraction works on the latched select of the access.
  aexm_dbus_lane u_lane (
    .i_wr_sel  (dwb_sel),
    .i_wr_data (dwb_do),
    .o_wr_data (w_wr_data),
    .i_rd_sel  (r_be),
    .i_rd_data (mem_rdata),
    .o_rd_data (w_rd_data)
  );

  // Upper address bits lie outside the memory window and are dropped.
  if (AW < 32) begin : g_adr_hi
    logic w_adr_hi_unused;
    assign w_adr_hi_unused = ^dwb_adr[31:AW];
  end

  // The wait limit is hit on the cycle the count would reach TMO, so mem_req
  // is seen for exactly TMO cycles before a timeout.
  assign w_tmo = ({1'b0, r_cnt} + 9'd1) == 9'(TMO);

  always_ff @(posedge gclk) begin
    // NOTE: state and data flops use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (grst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_di_nxt    = r_di;
    w_err_nxt   = 1'b0;
    w_accept    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (dwb_stb) begin
          if (dwb_sel == SEL_FSL) begin
            // FSL slot: complete immediately with no memory access.
            w_state_nxt = ST_DONE;
            w_di_nxt    = 32'h0;
          end else begin
            w_state_nxt = ST_REQ;
            w_accept    = 1'b1;
          end
        end
      end

      ST_REQ: begin
        // A grant on the limit cycle still wins over the timeout.
        if (mem_gnt) begin
          w_state_nxt = r_we ? ST_DONE : ST_RWAIT;
        end else if (w_tmo) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
          w_di_nxt    = ERR_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_RWAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = ST_DONE;
          w_di_nxt    = w_rd_data;
        end else if (w_tmo) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
          w_di_nxt    = ERR_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge gclk) begin
    // NOTE: the latched request fields are reset along with the control flops
    // so the memory port shows all zeros after reset, not stale data.
    if (grst) begin
      r_cnt   <= '0;
      r_di    <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_di   <= w_di_nxt;
      r_err  <= w_err_nxt;
      r_ack  <= (w_state_nxt == ST_DONE);
      r_busy <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_RWAIT);
      r_req  <= (w_state_nxt == ST_REQ);
      if (w_accept) begin
        r_we    <= dwb_we;
        r_be    <= dwb_sel;
        r_addr  <= dwb_adr[AW-1:0];
        r_wdata <= w_wr_data;
      end
    end
  end

  assign dwb_di    = r_di;
  assign dwb_ack   = r_ack;
  assign dwb_err   = r_err;
  assign dwb_busy  = r_busy;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_aexm_dbus_resp.sv
// -----------------------------------------------------------------------------
// tb_aexm_dbus_resp
//   Directed bench for aexm_dbus_resp with TMO=4. A transaction-level model
//   (queue of expected accesses plus arithmetic lane rules) is compared against
//   the DUT on every falling edge; the directed driver adds literal
//   expectations and cycle-exact latency checks.
// -----------------------------------------------------------------------------
module tb_aexm_dbus_resp;
  import aexm_pkg::*;

  localparam int AW  = 27;
  localparam int TMO = 4;

  logic          gclk = 1'b0;
  logic          grst = 1'b1;
  logic          dwb_stb = 1'b0;
  logic          dwb_we = 1'b0;
  logic [31:0]   dwb_adr = '0;
  logic [3:0]    dwb_sel = '0;
  logic [31:0]   dwb_do = '0;
  logic [31:0]   dwb_di;
  logic          dwb_ack;
  logic          dwb_err;
  logic          dwb_busy;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;

  always #5 gclk = ~gclk;

  aexm_dbus_resp #(.AW(AW), .TMO(TMO)) dut (
    .gclk(gclk), .grst(grst),
    .dwb_stb(dwb_stb), .dwb_we(dwb_we), .dwb_adr(dwb_adr), .dwb_sel(dwb_sel),
    .dwb_do(dwb_do), .dwb_di(dwb_di), .dwb_ack(dwb_ack), .dwb_err(dwb_err),
    .dwb_busy(dwb_busy), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic        tmo;
  } xact_t;

  xact_t exp_q[$];

  function automatic logic [31:0] model_wdata(input logic [3:0] sel, input logic [31:0] d);
    case (sel)
      4'h1, 4'h2, 4'h4, 4'h8: return {24'h0, d[7:0]} * 32'h0101_0101;
      4'h3, 4'hC:             return {16'h0, d[15:0]} * 32'h0001_0001;
      default:                return d;
    endcase
  endfunction

  function automatic logic [31:0] model_rdata(input logic [3:0] sel, input logic [31:0] rd);
    int lane;
    case (sel)
      4'h1, 4'h2, 4'h4, 4'h8: begin
        lane = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) lane = i;
        return (rd >> (8 * lane)) & 32'hFF;
      end
      4'h3:    return rd & 32'hFFFF;
      4'hC:    return rd >> 16;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] model_di(input xact_t x);
    if (x.tmo || x.sel == 4'h0) return 32'h0;
    return model_rdata(x.sel, x.rdata);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge gclk) begin : compare
    xact_t x;
    if (!grst) begin
      if (mem_req) begin
        check("req_has_xact", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          x = exp_q[0];
          check("mem_we",    32'(mem_we), 32'(x.we));
          check("mem_be",    32'(mem_be), 32'(x.sel));
          check("mem_addr",  32'(mem_addr), x.adr & ((32'd1 << AW) - 32'd1));
          if (x.we) check("mem_wdata", mem_wdata, model_wdata(x.sel, x.dat));
        end
      end
      if (dwb_ack) begin
        check("ack_has_xact", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          check("dwb_err", 32'(dwb_err), 32'(x.tmo));
          if (!x.we || x.tmo || x.sel == 4'h0) check("dwb_di", dwb_di, model_di(x));
          check("busy_at_ack", 32'(dwb_busy), 32'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  // g  : idle cycles with mem_req high before mem_gnt
  // rv : cycles from the grant edge to the rvalid edge (loads, >= 1)
  // lit: hand-computed mem_wdata for stores, dwb_di otherwise
  task automatic run(input string tag, input logic we, input logic [3:0] sel,
                     input logic [31:0] adr, input logic [31:0] d, input int g,
                     input int rv, input logic [31:0] rd, input logic tmo,
                     input logic [31:0] lit);
    xact_t x;
    x.we = we; x.sel = sel; x.adr = adr; x.dat = d; x.rdata = rd; x.tmo = tmo;
    exp_q.push_back(x);
    dwb_stb = 1'b1; dwb_we = we; dwb_adr = adr; dwb_sel = sel; dwb_do = d;
    tick();
    // Request fields change while the access is outstanding and must be ignored.
    dwb_we = ~we; dwb_adr = ~adr; dwb_sel = ~sel; dwb_do = ~d;
    if (sel == 4'h0) begin
      check({tag, "_fsl_noreq"}, 32'(mem_req), 32'd0);
    end else begin
      check({tag, "_busy_req"}, 32'(dwb_busy), 32'd1);
      if (we) check({tag, "_wdata_lit"}, mem_wdata, lit);
      if (tmo) begin
        for (int i = 0; i < TMO; i++) begin
          check({tag, "_req_held"}, 32'(mem_req), 32'd1);
          check({tag, "_no_ack"}, 32'(dwb_ack), 32'd0);
          tick();
        end
      end else begin
        for (int i = 0; i < g; i++) begin
          check({tag, "_req_held"}, 32'(mem_req), 32'd1);
          check({tag, "_no_ack"}, 32'(dwb_ack), 32'd0);
          tick();
        end
        check({tag, "_req_at_gnt"}, 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        if (!we) begin
          check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
          for (int i = 1; i < rv; i++) begin
            check({tag, "_busy_wait"}, 32'(dwb_busy), 32'd1);
            check({tag, "_no_ack"}, 32'(dwb_ack), 32'd0);
            tick();
          end
          mem_rdata = rd; mem_rvalid = 1'b1;
          tick();
          mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_0000;
        end
      end
    end
    check({tag, "_ack"}, 32'(dwb_ack), 32'd1);
    check({tag, "_req_off"}, 32'(mem_req), 32'd0);
    if (!we || sel == 4'h0 || tmo) check({tag, "_di_lit"}, dwb_di, lit);
    tick();
    dwb_stb = 1'b0;
    check({tag, "_ack_pulse"}, 32'(dwb_ack), 32'd0);
    check({tag, "_idle_busy"}, 32'(dwb_busy), 32'd0);
  endtask

  initial begin
    xact_t x;
    repeat (3) tick();
    check("rst_di",    dwb_di, 32'h0);
    check("rst_ack",   32'(dwb_ack), 32'd0);
    check("rst_err",   32'(dwb_err), 32'd0);
    check("rst_busy",  32'(dwb_busy), 32'd0);
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_we",    32'(mem_we), 32'd0);
    check("rst_be",    32'(mem_be), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'h0);
    grst = 1'b0;
    tick();

    //   tag         we   sel   adr           do            g  rv rdata         tmo  lit
    run("st_word",  1, 4'hF, 32'h0000_0010, 32'hCAFE_BABE, 0, 0, 32'h0,        0, 32'hCAFE_BABE);
    run("ld_b2",    0, 4'h4, 32'h0000_0020, 32'h0,         0, 3, 32'h1122_3344, 0, 32'h0000_0022);
    run("st_hlo",   1, 4'h3, 32'h0000_0030, 32'h0000_BEEF, 2, 0, 32'h0,        0, 32'hBEEF_BEEF);
    run("st_b3",    1, 4'h8, 32'hF800_0031, 32'h0000_005A, 1, 0, 32'h0,        0, 32'h5A5A_5A5A);
    run("fsl",      0, 4'h0, 32'h0000_0040, 32'h0,         0, 0, 32'h0,        0, 32'h0);
    run("ld_b3",    0, 4'h8, 32'h0000_0041, 32'h0,         1, 1, 32'hAABB_CCDD, 0, 32'h0000_00AA);
    run("ld_b1",    0, 4'h2, 32'h0000_0042, 32'h0,         0, 2, 32'hAABB_CCDD, 0, 32'h0000_00CC);
    run("ld_b0",    0, 4'h1, 32'h0000_0043, 32'h0,         0, 1, 32'hAABB_CCDD, 0, 32'h0000_00DD);
    run("ld_hhi",   0, 4'hC, 32'h0000_0044, 32'h0,         0, 1, 32'hAABB_CCDD, 0, 32'h0000_AABB);
    run("ld_hlo",   0, 4'h3, 32'h0000_0045, 32'h0,         0, 1, 32'hAABB_CCDD, 0, 32'h0000_CCDD);
    run("ld_word",  0, 4'hF, 32'h0000_0046, 32'h0,         0, 1, 32'hAABB_CCDD, 0, 32'hAABB_CCDD);
    run("ld_odd",   0, 4'h5, 32'h0000_0047, 32'h0,         0, 1, 32'hAABB_CCDD, 0, 32'hAABB_CCDD);
    // Grant on the last allowed cycle beats the timeout.
    run("st_gnt_lim", 1, 4'h2, 32'h0000_0050, 32'h0000_0077, TMO - 1, 0, 32'h0, 0, 32'h7777_7777);
    run("ld_tmo",   0, 4'hF, 32'h0000_0060, 32'h0,         0, 0, 32'h0,        1, 32'h0);

    // Late read data after the timeout must not produce an ack.
    mem_rdata = 32'hFFFF_FFFF; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("late_rv_no_ack", 32'(dwb_ack), 32'd0);
    check("late_rv_no_busy", 32'(dwb_busy), 32'd0);
    tick();
    check("late_rv_no_ack2", 32'(dwb_ack), 32'd0);
    run("ld_after_tmo", 0, 4'h3, 32'h0000_0070, 32'h0, 0, 2, 32'h1234_5678, 0, 32'h0000_5678);

    // Reset while waiting for read data.
    x.we = 1'b0; x.sel = 4'hF; x.adr = 32'h0000_0080; x.dat = 32'h0; x.rdata = 32'h0; x.tmo = 1'b0;
    exp_q.push_back(x);
    dwb_stb = 1'b1; dwb_we = 1'b0; dwb_sel = 4'hF; dwb_adr = 32'h0000_0080;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rwait_busy", 32'(dwb_busy), 32'd1);
    grst = 1'b1;
    tick();
    dwb_stb = 1'b0;
    exp_q.delete();
    check("mid_rst_req",  32'(mem_req), 32'd0);
    check("mid_rst_busy", 32'(dwb_busy), 32'd0);
    check("mid_rst_ack",  32'(dwb_ack), 32'd0);
    check("mid_rst_be",   32'(mem_be), 32'd0);
    grst = 1'b0;
    mem_rdata = 32'h0BAD_0BAD; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("post_rst_no_ack", 32'(dwb_ack), 32'd0);
    tick();
    check("post_rst_no_ack2", 32'(dwb_ack), 32'd0);
    run("ld_post_rst", 0, 4'h1, 32'h0000_0090, 32'h0, 0, 1, 32'h0000_00A5, 0, 32'h0000_00A5);
    run("st_post_rst", 1, 4'hC, 32'h0000_0091, 32'h0000_1357, 0, 0, 32'h0, 0, 32'h1357_1357);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
